// File: rtl/param_register_file_pkg.sv
// Shared type definitions for the parametrised register file.
package internal_defines;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_t;

endpackage

// File: rtl/param_register_file_init_sequencer.sv
// Post-reset clear sweep: steps one entry per cycle, then holds in RF_READY.
module rf_init_sequencer
  import internal_defines::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              ready,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t         r_state;
  logic [ADDR_W-1:0] r_cnt;

  // State and clear counter; the counter stops at DEPTH-1 instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
    end else if (r_state == RF_INIT) begin
      if (r_cnt == ADDR_W'(DEPTH - 1)) begin
        r_state <= RF_READY;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ready    = (r_state == RF_READY);
  assign clr_en   = (r_state == RF_INIT);
  assign clr_addr = r_cnt;

endmodule

// File: rtl/param_register_file.sv
// Two-read/one-write register file with clear sweep, optional bypass and
// optional hardwired-zero register 0.
module param_register_file
  import internal_defines::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b0,
  parameter int unsigned OBS_IDX  = DEPTH - 1
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_written_a,
  output logic              rd_written_b,
  output logic [DATA_W-1:0] obs_val,
  output logic              wr_err
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_written;
  logic              r_wr_err;

  logic              w_ready;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_in_range;
  logic              w_zero_wr;
  logic              w_wr_acc;
  logic              w_wr_drop;
  logic [DATA_W:0]   w_rd_a;
  logic [DATA_W:0]   w_rd_b;

  rf_init_sequencer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clock    (clock),
    .reset_n  (reset_n),
    .ready    (w_ready),
    .clr_en   (w_clr_en),
    .clr_addr (w_clr_addr)
  );

  // Compare with one extra bit so a power-of-two DEPTH is representable.
  assign w_wr_in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
  assign w_zero_wr     = ZERO_REG && (wr_addr == '0);
  assign w_wr_acc      = wr_en && w_ready && w_wr_in_range && !w_zero_wr;
  // Discards of register 0 under ZERO_REG are silent, so they are not drops.
  assign w_wr_drop     = wr_en && !(w_ready && w_wr_in_range);

  // Storage: cleared by the sweep (no reset, so it can map to RAM), then written.
  always_ff @(posedge clock) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Written-since-reset bitmap.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_written <= '0;
    end else if (w_wr_acc) begin
      r_written[wr_addr] <= 1'b1;
    end
  end

  // One-cycle error pulse for dropped write requests.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_wr_drop;
    end
  end

  // Returns {written, data} for one read port.
  function automatic logic [DATA_W:0] f_read(input logic [ADDR_W-1:0] addr);
    f_read = '0;
    if (w_ready && ({1'b0, addr} < (ADDR_W + 1)'(DEPTH)) &&
        !(ZERO_REG && (addr == '0))) begin
      if (BYPASS && w_wr_acc && (wr_addr == addr)) begin
        f_read = {1'b1, wr_data};
      end else begin
        f_read = {r_written[addr], r_mem[addr]};
      end
    end
  endfunction

  assign w_rd_a       = f_read(rd_addr_a);
  assign w_rd_b       = f_read(rd_addr_b);
  assign rd_data_a    = w_rd_a[DATA_W-1:0];
  assign rd_written_a = w_rd_a[DATA_W];
  assign rd_data_b    = w_rd_b[DATA_W-1:0];
  assign rd_written_b = w_rd_b[DATA_W];

  assign obs_val = w_ready ? r_mem[OBS_IDX] : '0;
  assign ready   = w_ready;
  assign wr_err  = r_wr_err;

endmodule
